inv_mix_columns_iter: RTL and testbench
=======================================

INV_MIX_COLUMNS_ITER -- requirements
Module: inv_mix_columns_iter

Interface
REQ-001 Parameter COLS_PER_CYCLE, default 1: AES state columns transformed per clock; legal values 1, 2, 4; any other value SHALL be a elaboration error.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  in_data holds a state to transform.
REQ-005 in_ready  output  1  block can accept a state.
REQ-006 in_data  input  128  AES state; column c = bits [127-32c -: 32], row 0 byte in the column's MSBs.
REQ-007 out_valid  output  1  out_data holds a finished result.
REQ-008 out_ready  input  1  downstream accepts out_data.
REQ-009 out_data  output  128  InvMixColumns(in_data), same byte layout as in_data.
REQ-010 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-011 Each output column byte r SHALL equal 0e*a[r] ^ 0b*a[r+1] ^ 0d*a[r+2] ^ 09*a[r+3] (indices mod 4), multiplication in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11b).
REQ-012 FSM states IDLE, BUSY, DONE; no other reachable states.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid=1, load in_data into the internal state register, clear column counter, go to BUSY.
REQ-014 BUSY: in_ready=0, out_valid=0; each cycle replace COLS_PER_CYCLE columns in place, starting at column 0, counter advancing by COLS_PER_CYCLE.
REQ-015 BUSY SHALL last exactly 4/COLS_PER_CYCLE cycles, then go to DONE.
REQ-016 DONE: out_valid=1, in_ready=0; out_data = fully transformed register; on out_ready=1 go to IDLE.
REQ-017 Latency: with acceptance at rising edge k, out_valid SHALL rise after edge k+4/COLS_PER_CYCLE (k+4 for default).
REQ-018 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0, for any stall length.
REQ-019 out_data SHALL be driven from the state register; value outside DONE is don't-care, except after reset.
REQ-020 in_valid and in_data SHALL be ignored outside IDLE; a held in_valid does not cause a second load until IDLE is re-entered.
REQ-021 No same-cycle input acceptance in DONE: a new state is accepted at the earliest one cycle after the output handshake.
REQ-022 out_ready asserted outside DONE SHALL have no effect.
REQ-023 Column counter SHALL saturate logic-free: wrap to 0 on entering DONE; never index beyond column 3.

Reset
REQ-024 rst_n=0 SHALL immediately force FSM=IDLE, counter=0, state register=0, out_valid=0, busy=0, out_data=0; in_ready=1 once rst_n=1.
REQ-025 Reset asserted in BUSY or DONE SHALL abort the operation; the partial/complete result is discarded and never presented.
REQ-026 First acceptance SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-027 FIPS-197 vector: in_data=128'h046681E5E0CB199A48F8D37A2806264C -> out_data=128'hD4BF5D30E0B452AEB84111F11E2798E5, out_valid after 4 cycles (COLS_PER_CYCLE=1), 2 (=2), 1 (=4).
REQ-028 Unit columns: in_data=128'h01000000_01010101_00000000_00000001 -> out_data=128'h0E090D0B_01010101_00000000_090D0B0E.
REQ-029 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid=1 and out_data unchanged throughout; in_ready=0; second in_valid ignored.
REQ-030 Back-to-back: in_valid held high, out_ready held high, two states queued -> each result appears once, 6-cycle accept-to-accept period (default), correct values.
REQ-031 Reset mid-BUSY after 2 cycles -> out_valid=0, out_data=0, in_ready=1 on release; next state transformed correctly.
REQ-032 Round trip: random 1000 states through MixColumns then this block -> output equals original state for every parameter value.

Source files
------------

// File: rtl/inv_mix_columns_iter_if.sv
// Handshake bundle for the iterative AES InvMixColumns block.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the input, out_valid/out_ready on the result.
// Ports: in_valid/in_ready/in_data (128b state in), out_valid/out_ready/out_data
//        (128b result out), busy (block not idle).
interface inv_mix_columns_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  // Producer/consumer side driving states in and taking results out.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  // Transform block side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one 128-bit state, COLS_PER_CYCLE columns per clock.
// Latency: result valid 4/COLS_PER_CYCLE cycles after the accepting edge; one idle cycle after each handshake.
// Backpressure: result held stable in DONE until out_ready; no input accepted outside IDLE.
// Ports: clk, rst_n (async active-low), bus (slave modport of inv_mix_columns_iter_if).
module inv_mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inv_mix_columns_iter_if.slave bus
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_fsm;
  state_t        w_fsm_nxt;
  logic [1:0]    r_col;
  logic [127:0]  r_state;
  logic [127:0]  w_state_step;
  logic [2:0]    w_col_sum;
  logic [1:0]    w_idx;
  logic          w_last;
  logic          w_load;
  logic          w_step;
  logic          w_in_ready;
  logic          w_out_valid;

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of InvMixColumns; byte 0 (row 0) sits in the MSBs.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0]  a  [4];
    logic [7:0]  m9 [4];
    logic [7:0]  mb [4];
    logic [7:0]  md [4];
    logic [7:0]  me [4];
    logic [7:0]  x2, x4, x8;
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
    return res;
  endfunction

  // The 2-bit counter wraps to 0 on the final step by itself; the carry
  // out of the 3-bit sum marks that final step.
  assign w_col_sum = {1'b0, r_col} + STEP;
  assign w_last    = w_col_sum[2];

  // Replace the COLS_PER_CYCLE columns starting at r_col. The 2-bit index
  // cannot address anything past column 3.
  always_comb begin
    w_state_step = r_state;
    w_idx        = r_col;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      w_idx = r_col + 2'(j);
      w_state_step[32*(3-int'(w_idx)) +: 32] = inv_mix_col(r_state[32*(3-int'(w_idx)) +: 32]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_load    = 1'b1;
          w_fsm_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_step = 1'b1;
        if (w_last) begin
          w_fsm_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_fsm_nxt = S_IDLE;
        end
      end
      default: begin
        w_fsm_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_col   <= '0;
    end else if (w_load) begin
      r_state <= bus.in_data;
      r_col   <= '0;
    end else if (w_step) begin
      r_state <= w_state_step;
      r_col   <= w_col_sum[1:0];
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_state;
  assign bus.busy      = (r_fsm != S_IDLE);

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Bench for inv_mix_columns_iter: three instances (1, 2, 4 columns per cycle) driven in lockstep.
// Latency: checks 4/COLS_PER_CYCLE cycles from accept to out_valid.
// Backpressure: exercises long out_ready stalls, back-to-back traffic and reset mid-operation.
module tb_inv_mix_columns_iter;

  localparam logic [127:0] FIPS_IN  = 128'h046681E5E0CB199A48F8D37A2806264C;
  localparam logic [127:0] FIPS_OUT = 128'hD4BF5D30E0B452AEB84111F11E2798E5;
  localparam logic [127:0] UNIT_IN  = 128'h01000000_01010101_00000000_00000001;
  localparam logic [127:0] UNIT_OUT = 128'h0E090D0B_01010101_00000000_090D0B0E;

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
    string        name;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         tb_in_valid;
  logic [127:0] tb_in_data;
  logic         tb_out_ready;

  logic         ov [3];
  logic         ir [3];
  logic         bz [3];
  logic [127:0] od [3];

  int n_pass  = 0;
  int n_total = 0;

  inv_mix_columns_iter_if bus [3] ();

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      assign bus[g].in_valid  = tb_in_valid;
      assign bus[g].in_data   = tb_in_data;
      assign bus[g].out_ready = tb_out_ready;
      assign ov[g] = bus[g].out_valid;
      assign ir[g] = bus[g].in_ready;
      assign bz[g] = bus[g].busy;
      assign od[g] = bus[g].out_data;

      inv_mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, got %0d of %0d passed", n_pass, n_total);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix with first row k (k0 in MSBs) applied to every column.
  function automatic logic [127:0] circ(input logic [127:0] s, input logic [31:0] k);
    logic [127:0] o;
    logic [7:0]   acc;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int t = 0; t < 4; t++) begin
          acc = acc ^ gmul(k[31-8*t -: 8], s[127-32*c-8*((r+t)%4) -: 8]);
        end
        o[127-32*c-8*r -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return circ(s, 32'h02030101);
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return circ(s, 32'h0E0B0D09);
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge with every instance idle. Accepts d on the next edge,
  // measures latency per instance, checks the result, then handshakes it away.
  task automatic do_txn(input logic [127:0] d, input logic [127:0] exp, input string nm);
    int lat [3];
    bit all_seen;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_in_ready_c%0d", nm, 1 << i), 128'(ir[i]), 128'(1));
      lat[i] = -1;
    end
    tb_in_valid = 1'b1;
    tb_in_data  = d;
    @(negedge clk);
    tb_in_valid = 1'b0;
    for (int t = 0; t <= 12; t++) begin
      all_seen = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (lat[i] < 0 && ov[i]) lat[i] = t;
        if (lat[i] < 0) all_seen = 1'b0;
      end
      if (all_seen) break;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_latency_c%0d", nm, 1 << i), 128'(lat[i]), 128'(4 >> i));
      chk($sformatf("%s_data_c%0d", nm, 1 << i), od[i], exp);
    end
    tb_out_ready = 1'b1;
    @(negedge clk);
    tb_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_released_c%0d", nm, 1 << i), 128'({ov[i], ir[i]}), 128'(2'b01));
    end
  endtask

  vec_t         vecs [4];
  logic [127:0] rnd;
  int           seen;

  initial begin
    vecs[0] = '{din: FIPS_IN,           dout: FIPS_OUT,          name: "fips"};
    vecs[1] = '{din: UNIT_IN,           dout: UNIT_OUT,          name: "unit_cols"};
    vecs[2] = '{din: 128'h0,            dout: 128'h0,            name: "zero"};
    vecs[3] = '{din: {16{8'h01}},       dout: {16{8'h01}},       name: "all_ones_bytes"};

    tb_in_valid  = 1'b0;
    tb_in_data   = '0;
    tb_out_ready = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_out_valid_c%0d", 1 << i), 128'(ov[i]), 128'(0));
      chk($sformatf("reset_out_data_c%0d", 1 << i), od[i], 128'h0);
      chk($sformatf("reset_busy_c%0d", 1 << i), 128'(bz[i]), 128'(0));
    end
    rst_n = 1'b1;

    // First vector goes in on the very first edge after reset release.
    for (int v = 0; v < 4; v++) begin
      do_txn(vecs[v].din, vecs[v].dout, vecs[v].name);
    end

    // Long stall in DONE with a second in_valid pending.
    tb_in_valid = 1'b1;
    tb_in_data  = FIPS_IN;
    @(negedge clk);
    tb_in_data  = 128'hDEADBEEF_0BADF00D_12345678_9ABCDEF0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("stall%0d_valid_c%0d", k, 1 << i), 128'(ov[i]), 128'(1));
        chk($sformatf("stall%0d_data_c%0d", k, 1 << i), od[i], FIPS_OUT);
        chk($sformatf("stall%0d_in_ready_c%0d", k, 1 << i), 128'(ir[i]), 128'(0));
      end
      @(negedge clk);
    end
    tb_in_valid  = 1'b0;
    tb_out_ready = 1'b1;
    @(negedge clk);
    tb_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall_no_reload_busy_c%0d", 1 << i), 128'(bz[i]), 128'(0));
    end

    // Back-to-back with in_valid and out_ready held high; judged on the 1-column instance.
    seen         = 0;
    tb_in_valid  = 1'b1;
    tb_in_data   = FIPS_IN;
    tb_out_ready = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      if (e == 1) tb_in_data = UNIT_IN;
      if (e == 6) chk("b2b_idle_gap_in_ready", 128'(ir[0]), 128'(1));
      if (e == 7) chk("b2b_second_accept_busy", 128'(bz[0]), 128'(1));
      if (ov[0]) begin
        if (seen == 0) begin
          chk("b2b_first_time", 128'(e), 128'(5));
          chk("b2b_first_data", od[0], FIPS_OUT);
        end else if (seen == 1) begin
          chk("b2b_second_time", 128'(e), 128'(11));
          chk("b2b_second_data", od[0], UNIT_OUT);
        end
        seen++;
      end
      if (e == 12) tb_in_valid = 1'b0;
    end
    chk("b2b_result_count", 128'(seen), 128'(2));
    repeat (8) @(negedge clk);
    tb_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_drained_c%0d", 1 << i), 128'(bz[i]), 128'(0));
    end

    // Reset two cycles into BUSY.
    tb_in_valid = 1'b1;
    tb_in_data  = FIPS_IN;
    @(negedge clk);
    tb_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst_out_valid_c%0d", 1 << i), 128'(ov[i]), 128'(0));
      chk($sformatf("midrst_out_data_c%0d", 1 << i), od[i], 128'h0);
      chk($sformatf("midrst_busy_c%0d", 1 << i), 128'(bz[i]), 128'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst_release_c%0d", 1 << i), {ov[i], ir[i], od[i]}, {2'b01, 128'h0});
    end
    do_txn(UNIT_IN, UNIT_OUT, "after_reset");

    // Random round trip: MixColumns in the model, InvMixColumns in the DUTs.
    for (int n = 0; n < 1000; n++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      if (n < 4) begin
        chk($sformatf("model_roundtrip%0d", n), inv_mix_columns(mix_columns(rnd)), rnd);
      end
      do_txn(mix_columns(rnd), rnd, $sformatf("rt%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
